interleaver_scheduler: RTL and testbench

Frame-level sequencer for the transmit block interleaver.
- Per PPDU, it sequences the SIGNAL symbol (always 48 coded bits) and then N_SYM DATA symbols.
- For each symbol it drives the interleaver size, enable and write/read phase, and gates the upstream coded-bit stream.
- Sits between the convolutional encoder/puncturer output and the interleaver/mapper.

---
 rtl/tx_il_pkg.sv | 40 ++++
 rtl/il_rate_decode.sv | 30 +++
 rtl/interleaver_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_interleaver_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_il_pkg.sv
// Shared types and constants for the transmit interleaver sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_il_pkg;

    localparam int SVC_TAIL = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIG_WR,
        ST_SIG_RD,
        ST_DAT_WR,
        ST_DAT_RD
    } il_state_e;

    localparam logic [3:0] RATE_6  = 4'b1101;
    localparam logic [3:0] RATE_9  = 4'b1111;
    localparam logic [3:0] RATE_12 = 4'b0101;
    localparam logic [3:0] RATE_18 = 4'b0111;
    localparam logic [3:0] RATE_24 = 4'b1001;
    localparam logic [3:0] RATE_36 = 4'b1011;
    localparam logic [3:0] RATE_48 = 4'b0001;
    localparam logic [3:0] RATE_54 = 4'b0011;

    localparam logic [8:0] CBPS_BPSK  = 9'd48;
    localparam logic [8:0] CBPS_QPSK  = 9'd96;
    localparam logic [8:0] CBPS_16QAM = 9'd192;
    localparam logic [8:0] CBPS_64QAM = 9'd288;
    localparam logic [8:0] CBPS_SIG   = 9'd48;

    localparam logic [7:0] DBPS_6  = 8'd24;
    localparam logic [7:0] DBPS_9  = 8'd36;
    localparam logic [7:0] DBPS_12 = 8'd48;
    localparam logic [7:0] DBPS_18 = 8'd72;
    localparam logic [7:0] DBPS_24 = 8'd96;
    localparam logic [7:0] DBPS_36 = 8'd144;
    localparam logic [7:0] DBPS_48 = 8'd192;
    localparam logic [7:0] DBPS_54 = 8'd216;

endpackage

// File: rtl/il_rate_decode.sv
// RATE code to coded/data bits per OFDM symbol; unlisted codes fall back to 48/24.
// Latency: combinational.
// Backpressure: none.
module il_rate_decode
    import tx_il_pkg::*;
(
    input  logic [3:0] rate_i,
    output logic [8:0] n_cbps_o,
    output logic [7:0] n_dbps_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = 1'b1;
        n_cbps_o = CBPS_BPSK;
        n_dbps_o = DBPS_6;
        case (rate_i)
            RATE_6:  begin n_cbps_o = CBPS_BPSK;  n_dbps_o = DBPS_6;  end
            RATE_9:  begin n_cbps_o = CBPS_BPSK;  n_dbps_o = DBPS_9;  end
            RATE_12: begin n_cbps_o = CBPS_QPSK;  n_dbps_o = DBPS_12; end
            RATE_18: begin n_cbps_o = CBPS_QPSK;  n_dbps_o = DBPS_18; end
            RATE_24: begin n_cbps_o = CBPS_16QAM; n_dbps_o = DBPS_24; end
            RATE_36: begin n_cbps_o = CBPS_16QAM; n_dbps_o = DBPS_36; end
            RATE_48: begin n_cbps_o = CBPS_64QAM; n_dbps_o = DBPS_48; end
            RATE_54: begin n_cbps_o = CBPS_64QAM; n_dbps_o = DBPS_54; end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/interleaver_scheduler.sv
// Per-PPDU interleaver sequencer: SIGNAL symbol then N_SYM DATA symbols, WR then RD each; RATE_CHECK_EN adds Err.
// Latency: all outputs registered; first WR cycle follows the accepted Start by one cycle.
// Backpressure: In_valid low stalls WR phases; RD phases never stall.
module interleaver_scheduler
    import tx_il_pkg::*;
#(
    parameter int LEN_W = 12,
    parameter int SYM_W = 11
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Rate,
    input  logic [LEN_W-1:0] Length,
    input  logic             In_valid,
    output logic             In_ready,
    output logic             Il_en,
    output logic             Il_wr,
    output logic [8:0]       Il_size,
    output logic             Il_sym_start,
    output logic             Out_valid,
    output logic [SYM_W-1:0] Sym_idx,
    output logic             Busy,
    output logic             Done
`ifdef RATE_CHECK_EN
    ,
    output logic             Err
`endif
);

    localparam logic [SYM_W-1:0] SYM_ONE = {{(SYM_W-1){1'b0}}, 1'b1};

    il_state_e        state_q;
    logic [8:0]       bit_cnt_q;
    logic [15:0]      rem_q;
    logic [8:0]       ncbps_q;
    logic [7:0]       ndbps_q;
    logic             in_ready_q;
    logic             il_en_q;
    logic             il_wr_q;
    logic [8:0]       il_size_q;
    logic             sym_start_q;
    logic             out_valid_q;
    logic [SYM_W-1:0] sym_idx_q;
    logic             busy_q;
    logic             done_q;

    logic [8:0]       dec_cbps;
    logic [7:0]       dec_dbps;
    logic             dec_valid;
    logic             rate_ok;
    logic             last_bit;
    logic [15:0]      frame_bits;

    il_rate_decode u_rate_decode (
        .rate_i   (Rate),
        .n_cbps_o (dec_cbps),
        .n_dbps_o (dec_dbps),
        .valid_o  (dec_valid)
    );

`ifdef RATE_CHECK_EN
    logic err_q;
    assign rate_ok = dec_valid;
    assign Err     = err_q;
`else
    logic unused_dec_valid;
    assign unused_dec_valid = dec_valid;
    assign rate_ok          = 1'b1;
`endif

    // Il_size always holds the current phase length, so it doubles as the bit-count limit.
    assign last_bit   = (bit_cnt_q == il_size_q - 9'd1);
    assign frame_bits = 16'(SVC_TAIL) + 16'({Length, 3'b000});

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rem_q       <= '0;
            ncbps_q     <= '0;
            ndbps_q     <= '0;
            in_ready_q  <= 1'b0;
            il_en_q     <= 1'b0;
            il_wr_q     <= 1'b0;
            il_size_q   <= '0;
            sym_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            sym_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RATE_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            sym_start_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef RATE_CHECK_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (Start && Length != '0) begin
                        if (rate_ok) begin
                            state_q     <= ST_SIG_WR;
                            ncbps_q     <= dec_cbps;
                            ndbps_q     <= dec_dbps;
                            rem_q       <= frame_bits;
                            bit_cnt_q   <= '0;
                            sym_idx_q   <= '0;
                            busy_q      <= 1'b1;
                            in_ready_q  <= 1'b1;
                            il_en_q     <= 1'b1;
                            il_wr_q     <= 1'b1;
                            il_size_q   <= CBPS_SIG;
                            sym_start_q <= 1'b1;
                        end
`ifdef RATE_CHECK_EN
                        else begin
                            err_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_SIG_WR, ST_DAT_WR: begin
                    if (In_valid && in_ready_q) begin
                        if (last_bit) begin
                            state_q     <= (state_q == ST_SIG_WR) ? ST_SIG_RD : ST_DAT_RD;
                            bit_cnt_q   <= '0;
                            in_ready_q  <= 1'b0;
                            il_wr_q     <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 9'd1;
                        end
                    end
                end
                ST_SIG_RD: begin
                    if (last_bit) begin
                        state_q     <= ST_DAT_WR;
                        bit_cnt_q   <= '0;
                        sym_idx_q   <= SYM_ONE;
                        il_size_q   <= ncbps_q;
                        in_ready_q  <= 1'b1;
                        il_wr_q     <= 1'b1;
                        out_valid_q <= 1'b0;
                        sym_start_q <= 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 9'd1;
                    end
                end
                ST_DAT_RD: begin
                    if (last_bit) begin
                        bit_cnt_q   <= '0;
                        out_valid_q <= 1'b0;
                        // Remaining-bits countdown replaces a ceil() divider for N_SYM.
                        if (rem_q > {8'd0, ndbps_q}) begin
                            state_q     <= ST_DAT_WR;
                            rem_q       <= rem_q - {8'd0, ndbps_q};
                            sym_idx_q   <= sym_idx_q + SYM_ONE;
                            in_ready_q  <= 1'b1;
                            il_wr_q     <= 1'b1;
                            sym_start_q <= 1'b1;
                        end else begin
                            state_q   <= ST_IDLE;
                            il_en_q   <= 1'b0;
                            il_size_q <= '0;
                            sym_idx_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 9'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign In_ready     = in_ready_q;
    assign Il_en        = il_en_q;
    assign Il_wr        = il_wr_q;
    assign Il_size      = il_size_q;
    assign Il_sym_start = sym_start_q;
    assign Out_valid    = out_valid_q;
    assign Sym_idx      = sym_idx_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

endmodule

// File: tb/tb_interleaver_scheduler.sv
// Bench for interleaver_scheduler: a phase-list reference model checked every cycle plus literal frame checks.
module tb_interleaver_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic        In_valid;
    logic        In_ready, Il_en, Il_wr, Il_sym_start, Out_valid, Busy, Done;
    logic [8:0]  Il_size;
    logic [10:0] Sym_idx;
    logic        Err_w;

    always #5 Clk = ~Clk;

    interleaver_scheduler dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Rate         (Rate),
        .Length       (Length),
        .In_valid     (In_valid),
        .In_ready     (In_ready),
        .Il_en        (Il_en),
        .Il_wr        (Il_wr),
        .Il_size      (Il_size),
        .Il_sym_start (Il_sym_start),
        .Out_valid    (Out_valid),
        .Sym_idx      (Sym_idx),
        .Busy         (Busy),
`ifdef RATE_CHECK_EN
        .Done         (Done),
        .Err          (Err_w)
`else
        .Done         (Done)
`endif
    );

`ifndef RATE_CHECK_EN
    assign Err_w = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int iv_mode = 0;

    // Reference model: a frame is a flat list of phases, each consumed in order.
    typedef struct packed {
        logic       wr;
        logic [8:0] size;
        logic [10:0] idx;
    } ph_t;

    ph_t mq[$];
    int  mcnt = 0;
    bit  m_done = 0, m_err = 0, m_sst = 0;

    // Frame statistics sampled each cycle.
    int busy_cycles, max_idx, max_size, wr1, rd1, bad_ready, t_start, done_delta;
    bit done_seen, err_seen, saw288;

    function automatic void ref_rate(input logic [3:0] r, output int cb, output int db, output bit ok);
        ok = 1;
        case (r)
            4'b1101: begin cb = 48;  db = 24;  end
            4'b1111: begin cb = 48;  db = 36;  end
            4'b0101: begin cb = 96;  db = 48;  end
            4'b0111: begin cb = 96;  db = 72;  end
            4'b1001: begin cb = 192; db = 96;  end
            4'b1011: begin cb = 192; db = 144; end
            4'b0001: begin cb = 288; db = 192; end
            4'b0011: begin cb = 288; db = 216; end
            default: begin cb = 48;  db = 24;  ok = 0; end
        endcase
`ifndef RATE_CHECK_EN
        ok = 1;
`endif
    endfunction

    function automatic void model_edge();
        int cb, db, nbits, nsym;
        bit ok;
        m_done = 0;
        m_err  = 0;
        m_sst  = 0;
        if (Reset) begin
            mq.delete();
            mcnt = 0;
            return;
        end
        if (mq.size() == 0) begin
            if (Start && Length != 0) begin
                ref_rate(Rate, cb, db, ok);
                if (!ok) begin
                    m_err = 1;
                end else begin
                    nbits = 22 + 8 * int'(Length);
                    nsym  = (nbits + db - 1) / db;
                    mq.push_back('{wr: 1'b1, size: 9'd48, idx: 11'd0});
                    mq.push_back('{wr: 1'b0, size: 9'd48, idx: 11'd0});
                    for (int k = 1; k <= nsym; k++) begin
                        mq.push_back('{wr: 1'b1, size: 9'(cb), idx: 11'(k)});
                        mq.push_back('{wr: 1'b0, size: 9'(cb), idx: 11'(k)});
                    end
                    mcnt  = 0;
                    m_sst = 1;
                end
            end
        end else begin
            if (!mq[0].wr || In_valid) mcnt++;
            if (mcnt == int'(mq[0].size)) begin
                void'(mq.pop_front());
                mcnt = 0;
                if (mq.size() == 0) m_done = 1;
                else if (mq[0].wr) m_sst = 1;
            end
        end
    endfunction

    function automatic logic [27:0] exp_vec();
        ph_t h;
        logic act;
        act = (mq.size() != 0);
        h = act ? mq[0] : '0;
        return {act & h.wr, act, act & h.wr, h.size, m_sst, act & ~h.wr, h.idx, act, m_done, m_err};
    endfunction

    function automatic logic [27:0] act_vec();
        return {In_ready, Il_en, Il_wr, Il_size, Il_sym_start, Out_valid, Sym_idx, Busy, Done, Err_w};
    endfunction

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic clear_stats();
        busy_cycles = 0; max_idx = 0; max_size = 0; wr1 = 0; rd1 = 0; bad_ready = 0;
        t_start = 0; done_delta = 0; done_seen = 0; err_seen = 0; saw288 = 0;
    endtask

    // In_valid driver: held high, toggling, or random.
    initial begin
        In_valid = 1'b0;
        forever begin
            @(posedge Clk);
            #2;
            case (iv_mode)
                0:       In_valid = 1'b1;
                1:       In_valid = ~In_valid;
                default: In_valid = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(posedge Clk);
            cyc++;
            model_edge();
            @(negedge Clk);
            if (Reset) begin
                mq.delete();
                mcnt = 0; m_done = 0; m_sst = 0; m_err = 0;
            end
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL cycle_cmp cyc=%0d got=%h expected=%h", cyc, act_vec(), exp_vec());
            end
            if (Start && !Busy && Length != 0) t_start = cyc;
            if (Busy) busy_cycles++;
            if (int'(Sym_idx) > max_idx) max_idx = int'(Sym_idx);
            if (int'(Il_size) > max_size) max_size = int'(Il_size);
            if (Il_size == 9'd288) saw288 = 1;
            if (Il_en && Il_wr && Sym_idx == 11'd1) wr1++;
            if (Out_valid && Sym_idx == 11'd1) rd1++;
            if (In_ready && Out_valid) bad_ready++;
            if (Err_w) err_seen = 1;
            if (Done) begin
                done_seen  = 1;
                done_delta = cyc - t_start;
            end
        end
    end

    task automatic start_frame(input logic [3:0] r, input logic [11:0] l);
        @(posedge Clk);
        #2;
        Rate = r; Length = l; Start = 1'b1;
        @(posedge Clk);
        #2;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(negedge Clk);
            #1;
            n++;
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s_timeout got=no_done expected=done within %0d cycles", name, budget);
        end
    endtask

    logic [3:0] rates [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011};

    initial begin
        int n;
        Reset = 1'b1; Start = 1'b0; Rate = 4'b1101; Length = '0;
        clear_stats();
        repeat (3) @(negedge Clk);
        check("reset_state", int'(act_vec()), 0);
        @(posedge Clk);
        #2 Reset = 1'b0;

        // Rate 6, one octet: 2 DATA symbols, Done 289 cycles after Start.
        clear_stats();
        start_frame(4'b1101, 12'd1);
        wait_done("frame_a", 1000);
        check("a_done_delta", done_delta, 289);
        check("a_max_idx", max_idx, 2);
        check("a_busy_cycles", busy_cycles, 288);

        // Rate 54, 100 octets, with ignored Start pulses during the frame.
        clear_stats();
        start_frame(4'b0011, 12'd100);
        repeat (200) @(negedge Clk);
        start_frame(4'b1101, 12'd7);
        repeat (500) @(negedge Clk);
        start_frame(4'b0101, 12'd3);
        wait_done("frame_b", 4000);
        check("b_busy_cycles", busy_cycles, 2400);
        check("b_max_idx", max_idx, 4);
        check("b_saw_288", int'(saw288), 1);

        // Zero length is ignored.
        clear_stats();
        start_frame(4'b0101, 12'd0);
        repeat (5) @(negedge Clk);
        check("len0_busy", busy_cycles, 0);

        // Toggling In_valid stretches WR only.
        iv_mode = 1;
        clear_stats();
        start_frame(4'b0101, 12'd5);
        wait_done("frame_tog", 3000);
        check("tog_wr_len", int'(wr1 == 191 || wr1 == 192), 1);
        check("tog_rd_len", rd1, 96);
        check("tog_ready_in_rd", bad_ready, 0);
        check("tog_max_idx", max_idx, 2);
        iv_mode = 0;

        // Reset in the middle of DATA symbol 1 read.
        clear_stats();
        start_frame(4'b1101, 12'd10);
        n = 0;
        while (!(Out_valid && Sym_idx == 11'd1) && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check("rst_reach_dat_rd", int'(Out_valid && Sym_idx == 11'd1), 1);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("rst_async_outs", int'(act_vec()), 0);
        @(posedge Clk);
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_no_done", int'(done_seen), 0);
        clear_stats();
        start_frame(4'b1101, 12'd1);
        wait_done("frame_post_rst", 1000);
        check("post_rst_done_delta", done_delta, 289);

        // Unlisted rate code.
        clear_stats();
        start_frame(4'b0000, 12'd3);
`ifdef RATE_CHECK_EN
        repeat (4) @(negedge Clk);
        check("badrate_err", int'(err_seen), 1);
        check("badrate_busy", busy_cycles, 0);
`else
        wait_done("frame_badrate", 1000);
        check("badrate_busy", busy_cycles, 288);
        check("badrate_size", max_size, 48);
`endif

        // Randomised frames.
        iv_mode = 2;
        for (int i = 0; i < 8; i++) begin
            clear_stats();
            start_frame(rates[$urandom_range(0, 7)], 12'($urandom_range(1, 40)));
            wait_done("frame_rand", 20000);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
